// File: rtl/seg_led_scan_decoder.sv
// seg_led_scan_decoder
// Receive side of the multiplexed seven-segment bus. Samples sel/seg_led,
// waits for each digit dwell to settle, decodes the active-low pattern back
// to a hex nibble and publishes a complete frame once every digit is seen.
module seg_led_scan_decoder #(
    parameter int DIGITS     = 6,
    parameter int STABLE_CYC = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DIGITS-1:0]     sel,
    input  logic [7:0]            seg_led,
    output logic [4*DIGITS-1:0]   data,
    output logic [DIGITS-1:0]     point,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_valid,
    output logic                  seg_err,
    output logic                  sel_err
);

    localparam int CNT_W = $clog2(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);
    localparam int IDX_W = $clog2(DIGITS);
    localparam int LOW_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic       hit;
        logic       dark;
        logic [3:0] nib;
    } dec_t;

    // Active-low segment table; anything not listed is an illegal pattern.
    function automatic dec_t decode_seg(input logic [6:0] pat);
        dec_t r;
        r = '{hit: 1'b1, dark: 1'b0, nib: 4'h0};
        case (pat)
            7'h40: r.nib = 4'h0;
            7'h79: r.nib = 4'h1;
            7'h24: r.nib = 4'h2;
            7'h30: r.nib = 4'h3;
            7'h19: r.nib = 4'h4;
            7'h12: r.nib = 4'h5;
            7'h02: r.nib = 4'h6;
            7'h78: r.nib = 4'h7;
            7'h00: r.nib = 4'h8;
            7'h10: r.nib = 4'h9;
            7'h08: r.nib = 4'hA;
            7'h03: r.nib = 4'hB;
            7'h46: r.nib = 4'hC;
            7'h21: r.nib = 4'hD;
            7'h06: r.nib = 4'hE;
            7'h0E: r.nib = 4'hF;
            7'h7F: r.dark = 1'b1;
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0]   sel_meta, sel_s, sel_prev;
    logic [7:0]          seg_meta, seg_s, seg_prev;
    logic [CNT_W-1:0]    cnt;
    state_t              state, state_next;
    logic                accept;
    logic                same;
    logic                sel_idle;
    logic [LOW_W-1:0]    low_cnt;
    logic [IDX_W-1:0]    low_idx;
    logic                one_cold;
    dec_t                dec;
    logic                store;
    logic [DIGITS-1:0]   mask, mask_next;
    logic                mask_full;
    logic [4*DIGITS-1:0] shadow_data;
    logic [DIGITS-1:0]   shadow_point;
    logic [DIGITS-1:0]   shadow_blank;

    // Two-stage synchroniser; resets to the idle bus value (all dark, no digit selected).
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_meta <= '1;
            sel_s    <= '1;
            seg_meta <= '1;
            seg_s    <= '1;
        end else begin
            sel_meta <= sel;
            sel_s    <= sel_meta;
            seg_meta <= seg_led;
            seg_s    <= seg_meta;
        end
    end

    assign same     = (sel_s == sel_prev) && (seg_s == seg_prev);
    assign sel_idle = &sel_s;

    // Previous sample and saturating stability counter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sel_prev <= '1;
            seg_prev <= '1;
            cnt      <= '0;
        end else begin
            sel_prev <= sel_s;
            seg_prev <= seg_s;
            if (!same) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; accept fires once per settled dwell, then HOLD blocks re-accepts.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (!sel_idle) state_next = TRACK;
            end
            TRACK: begin
                if (!same) begin
                    state_next = sel_idle ? IDLE : TRACK;
                end else if (cnt == CNT_MAX) begin
                    accept     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!same) state_next = sel_idle ? IDLE : TRACK;
            end
            default: state_next = IDLE;
        endcase
    end

    // Classify the select bus: how many bits are low and which one (last found).
    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!sel_s[i]) begin
                low_cnt = low_cnt + LOW_W'(1);
                low_idx = IDX_W'(i);
            end
        end
    end

    assign one_cold  = (low_cnt == LOW_W'(1));
    assign dec       = decode_seg(seg_s[6:0]);
    assign store     = accept && one_cold && dec.hit;
    assign mask_full = &mask;

    // Mask clears on the commit cycle; a newly stored digit sets its bit.
    always_comb begin
        mask_next = mask_full ? '0 : mask;
        if (store) mask_next[low_idx] = 1'b1;
    end

    // Shadow capture, error pulses and atomic frame commit.
    // NOTE: the shadow store is reset on purpose so a reset mid-frame leaves no stale digits.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mask         <= '0;
            shadow_data  <= '0;
            shadow_point <= '0;
            shadow_blank <= '0;
            data         <= '0;
            point        <= '0;
            blank        <= '0;
            frame_valid  <= 1'b0;
            seg_err      <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            sel_err     <= 1'b0;
            mask        <= mask_next;
            if (mask_full) begin
                data        <= shadow_data;
                point       <= shadow_point;
                blank       <= shadow_blank;
                frame_valid <= 1'b1;
            end
            if (accept) begin
                if (!one_cold) begin
                    sel_err <= 1'b1;
                end else if (!dec.hit) begin
                    seg_err <= 1'b1;
                end else begin
                    shadow_data[int'(low_idx)*4 +: 4] <= dec.nib;
                    shadow_point[low_idx]             <= ~seg_s[7];
                    shadow_blank[low_idx]             <= dec.dark;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_led_scan_decoder.sv
// tb_seg_led_scan_decoder
// Directed scans of the seven-segment bus; expected frames and error pulses are
// queued by the stimulus and consumed by an independent output monitor.
module tb_seg_led_scan_decoder;

    localparam int DIGITS = 6;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [DIGITS-1:0]   sel = '1;
    logic [7:0]          seg_led = '1;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   point;
    logic [DIGITS-1:0]   blank;
    logic                frame_valid;
    logic                seg_err;
    logic                sel_err;

    seg_led_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYC(16)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .sel         (sel),
        .seg_led     (seg_led),
        .data        (data),
        .point       (point),
        .blank       (blank),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .sel_err     (sel_err)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [23:0] d;
        logic [5:0]  p;
        logic [5:0]  b;
    } frame_t;

    frame_t      frame_q[$];
    logic [23:0] seg_q[$];
    int          sel_pending = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Hand-written active-low segment patterns.
    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic hold(input logic [5:0] s, input logic [7:0] g, input int n);
        sel     = s;
        seg_led = g;
        repeat (n) @(negedge sys_clk);
    endtask

    function automatic logic [5:0] sel_of(input int k);
        return ~(6'(1) << k);
    endfunction

    task automatic scan_digit(input int k, input logic [3:0] nib, input logic dp, input logic dark);
        hold(sel_of(k), {~dp, dark ? 7'h7F : pat(nib)}, 20);
    endtask

    task automatic scan_frame(input logic [23:0] value, input logic [5:0] dp,
                              input logic [5:0] dark, input int garbage);
        for (int k = 0; k < DIGITS; k++) begin
            if (garbage > 0) hold(sel_of(k), 8'hD5, garbage);
            scan_digit(k, value[4*k +: 4], dp[k], dark[k]);
        end
    endtask

    task automatic idle(input int n);
        hold(6'h3F, 8'hFF, n);
    endtask

    // Wait (bounded) for every queued expectation to be consumed.
    task automatic drain(input string name);
        int n;
        n = 0;
        while ((frame_q.size() != 0 || seg_q.size() != 0 || sel_pending != 0) && n < 200) begin
            @(negedge sys_clk);
            n++;
        end
        check(name, 32'(frame_q.size() + seg_q.size() + sel_pending), 0);
        frame_q.delete();
        seg_q.delete();
        sel_pending = 0;
    endtask

    // Monitor: samples outputs on the falling edge and pops the matching expectation.
    initial begin
        frame_t      f;
        logic [23:0] d;
        forever begin
            @(negedge sys_clk);
            if (frame_valid) begin
                check("frame_valid_expected", 32'(frame_q.size() != 0), 1);
                if (frame_q.size() != 0) begin
                    f = frame_q.pop_front();
                    check("frame_data", 32'(data), 32'(f.d));
                    check("frame_point", 32'(point), 32'(f.p));
                    check("frame_blank", 32'(blank), 32'(f.b));
                end
            end
            if (seg_err) begin
                check("seg_err_expected", 32'(seg_q.size() != 0), 1);
                if (seg_q.size() != 0) begin
                    d = seg_q.pop_front();
                    check("seg_err_data_hold", 32'(data), 32'(d));
                end
            end
            if (sel_err) begin
                check("sel_err_expected", 32'(sel_pending != 0), 1);
                if (sel_pending != 0) sel_pending--;
            end
        end
    end

    initial begin
        // Reset held 100 ns with an idle bus.
        #100;
        check("rst_data", 32'(data), 0);
        check("rst_point", 32'(point), 0);
        check("rst_blank", 32'(blank), 0);
        check("rst_frame_valid", 32'(frame_valid), 0);
        check("rst_seg_err", 32'(seg_err), 0);
        check("rst_sel_err", 32'(sel_err), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Idle bus for 1000 cycles: no pulses, outputs stay zero.
        idle(1000);
        check("idle_data", 32'(data), 0);
        check("idle_point", 32'(point), 0);
        check("idle_blank", 32'(blank), 0);
        drain("idle_pending");

        // Two clean scans of "123456".
        frame_q.push_back('{d: 24'h123456, p: 6'h00, b: 6'h00});
        scan_frame(24'h123456, 6'h00, 6'h00, 0);
        frame_q.push_back('{d: 24'h123456, p: 6'h00, b: 6'h00});
        scan_frame(24'h123456, 6'h00, 6'h00, 0);
        idle(40);
        drain("scan_twice_pending");

        // Short garbage bursts between digits are ignored.
        frame_q.push_back('{d: 24'h123456, p: 6'h00, b: 6'h00});
        scan_frame(24'h123456, 6'h00, 6'h00, 5);
        idle(40);
        drain("garbage_pending");

        // Digit2 dwells on an illegal pattern: seg_err, no frame, data untouched.
        seg_q.push_back(24'h123456);
        for (int k = 0; k < DIGITS; k++) begin
            if (k == 2) hold(sel_of(k), 8'hD5, 20);
            else        scan_digit(k, 24'h123456 >> (4*k), 1'b0, 1'b0);
        end
        idle(40);
        drain("seg_err_pending");
        check("seg_err_data_kept", 32'(data), 32'h123456);
        frame_q.push_back('{d: 24'h123756, p: 6'h00, b: 6'h00});
        scan_digit(2, 4'h7, 1'b0, 1'b0);
        idle(40);
        drain("rescan_pending");

        // Two selects low mid-frame: sel_err, nothing stored into digits 0/1.
        for (int k = 0; k < 5; k++) scan_digit(k, 24'h987654 >> (4*k), 1'b0, 1'b0);
        sel_pending++;
        hold(6'b111100, 8'hC0, 20);
        frame_q.push_back('{d: 24'h987654, p: 6'h00, b: 6'h00});
        scan_digit(5, 4'h9, 1'b0, 1'b0);
        idle(40);
        drain("sel_err_pending");

        // Reset mid-frame discards the partial mask.
        for (int k = 0; k < 3; k++) scan_digit(k, 4'(k + 1), 1'b1, 1'b0);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("midrst_data", 32'(data), 0);
        check("midrst_point", 32'(point), 0);
        check("midrst_blank", 32'(blank), 0);
        sys_rst_n = 1'b1;
        scan_digit(3, 4'hC, 1'b0, 1'b0);
        scan_digit(4, 4'hB, 1'b0, 1'b0);
        scan_digit(5, 4'hA, 1'b0, 1'b1);
        idle(60);
        drain("midrst_no_frame");

        // Digits 3-5 already hold C/B/dark, so the frame closes once digits 0-2 land.
        frame_q.push_back('{d: 24'h0BCDEF, p: 6'h01, b: 6'h20});
        scan_frame(24'hABCDEF, 6'h01, 6'h20, 0);
        idle(40);
        drain("abcdef_pending");
        check("final_data", 32'(data), 32'h0BCDEF);
        check("final_point", 32'(point), 32'h01);
        check("final_blank", 32'(blank), 32'h20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
